// File: rtl/warp_issue_stage.sv
// Warp issue stage: captures one warp instruction and fans it out per lane until every active lane
// has been taken by its core. Define WARP_ISSUE_PERF_EN to add perf_warps/perf_stall_cycles.
module warp_issue_stage #(
   parameter int unsigned W           = 32,
   parameter int unsigned NUM_THREADS = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [NUM_THREADS-1:0]           in_mask,
   input  logic [5:0]                       in_opcode,
   input  logic                             in_is_fp,
   input  logic [NUM_THREADS-1:0][W-1:0]    in_op1,
   input  logic [NUM_THREADS-1:0][W-1:0]    in_op2,
   input  logic [NUM_THREADS-1:0]           core_ready,
   output logic [NUM_THREADS-1:0]           thread_valid,
   output logic [NUM_THREADS-1:0][5:0]      thread_opcode,
   output logic [NUM_THREADS-1:0]           thread_is_fp,
   output logic [NUM_THREADS-1:0][W-1:0]    thread_op1,
   output logic [NUM_THREADS-1:0][W-1:0]    thread_op2,
   output logic                             busy,
   output logic                             warp_done
`ifdef WARP_ISSUE_PERF_EN
   ,
   output logic [31:0]                      perf_warps,
   output logic [31:0]                      perf_stall_cycles
`endif
);

   typedef enum logic [0:0] {StIdle, StIssue} state_e;

   state_e                          state_q;
   logic [NUM_THREADS-1:0]          pending_q;
   logic [5:0]                      opcode_q;
   logic                            is_fp_q;
   logic [NUM_THREADS-1:0][W-1:0]   op1_q;
   logic [NUM_THREADS-1:0][W-1:0]   op2_q;
   logic                            warp_done_q;
   logic [NUM_THREADS-1:0]          remaining;

`ifdef WARP_ISSUE_PERF_EN
   logic [31:0]                     perf_warps_q;
   logic [31:0]                     perf_stall_q;
`endif

   // Lanes still waiting after this cycle's handshakes.
   assign remaining = pending_q & ~core_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         pending_q   <= '0;
         opcode_q    <= '0;
         is_fp_q     <= 1'b0;
         op1_q       <= '0;
         op2_q       <= '0;
         warp_done_q <= 1'b0;
`ifdef WARP_ISSUE_PERF_EN
         perf_warps_q <= '0;
         perf_stall_q <= '0;
`endif
      end else begin
         warp_done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  opcode_q  <= in_opcode;
                  is_fp_q   <= in_is_fp;
                  op1_q     <= in_op1;
                  op2_q     <= in_op2;
                  pending_q <= in_mask;
                  if (in_mask == '0) begin
                     warp_done_q <= 1'b1;
`ifdef WARP_ISSUE_PERF_EN
                     perf_warps_q <= perf_warps_q + 32'd1;
`endif
                  end else begin
                     state_q <= StIssue;
                  end
               end
            end
            StIssue: begin
               pending_q <= remaining;
               if (remaining == '0) begin
                  state_q     <= StIdle;
                  warp_done_q <= 1'b1;
`ifdef WARP_ISSUE_PERF_EN
                  perf_warps_q <= perf_warps_q + 32'd1;
`endif
               end else begin
`ifdef WARP_ISSUE_PERF_EN
                  perf_stall_q <= perf_stall_q + 32'd1;
`endif
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign in_ready      = (state_q == StIdle);
   assign busy          = (state_q == StIssue);
   assign warp_done     = warp_done_q;
   assign thread_valid  = pending_q;
   assign thread_opcode = {NUM_THREADS{opcode_q}};
   assign thread_is_fp  = {NUM_THREADS{is_fp_q}};
   assign thread_op1    = op1_q;
   assign thread_op2    = op2_q;

`ifdef WARP_ISSUE_PERF_EN
   assign perf_warps        = perf_warps_q;
   assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_warp_issue_stage.sv
// Bench for warp_issue_stage: per-cycle checks from the driver plus a completion scoreboard that
// is popped on every warp_done pulse.
module tb_warp_issue_stage;

   localparam int unsigned W  = 32;
   localparam int unsigned NT = 32;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [NT-1:0]           in_mask = '0;
   logic [5:0]              in_opcode = '0;
   logic                    in_is_fp = 1'b0;
   logic [NT-1:0][W-1:0]    in_op1 = '0;
   logic [NT-1:0][W-1:0]    in_op2 = '0;
   logic [NT-1:0]           core_ready = '0;
   logic [NT-1:0]           thread_valid;
   logic [NT-1:0][5:0]      thread_opcode;
   logic [NT-1:0]           thread_is_fp;
   logic [NT-1:0][W-1:0]    thread_op1;
   logic [NT-1:0][W-1:0]    thread_op2;
   logic                    busy;
   logic                    warp_done;
`ifdef WARP_ISSUE_PERF_EN
   logic [31:0]             perf_warps;
   logic [31:0]             perf_stall_cycles;
   logic [31:0]             stall0;
`endif

   warp_issue_stage #(.W(W), .NUM_THREADS(NT)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_mask       (in_mask),
      .in_opcode     (in_opcode),
      .in_is_fp      (in_is_fp),
      .in_op1        (in_op1),
      .in_op2        (in_op2),
      .core_ready    (core_ready),
      .thread_valid  (thread_valid),
      .thread_opcode (thread_opcode),
      .thread_is_fp  (thread_is_fp),
      .thread_op1    (thread_op1),
      .thread_op2    (thread_op2),
      .busy          (busy),
      .warp_done     (warp_done)
`ifdef WARP_ISSUE_PERF_EN
      ,
      .perf_warps        (perf_warps),
      .perf_stall_cycles (perf_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic [5:0]  opc;
      logic        fp;
      logic [31:0] op1_0;
      logic [31:0] op2_0;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [31:0] op1_hold;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [NT-1:0] mask, input logic [5:0] opc, input logic fp);
      in_valid  = 1'b1;
      in_mask   = mask;
      in_opcode = opc;
      in_is_fp  = fp;
      for (int i = 0; i < NT; i++) begin
         in_op1[i] = $urandom;
         in_op2[i] = $urandom;
      end
   endtask

   // Expected completion: warp_done seen lat cycles after the accepting edge is armed.
   task automatic expect_done(input int unsigned lat);
      sb.push_back('{cyc: cyc + lat, opc: in_opcode, fp: in_is_fp,
                     op1_0: in_op1[0], op2_0: in_op2[0]});
   endtask

   always @(negedge clk) begin
      if (rst && warp_done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            chk("done_opcode", 64'(thread_opcode[NT-1]), 64'(e.opc));
            chk("done_is_fp", 64'(thread_is_fp[3]), 64'(e.fp));
            chk("done_op1", 64'(thread_op1[0]), 64'(e.op1_0));
            chk("done_op2", 64'(thread_op2[0]), 64'(e.op2_0));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      repeat (2) tick();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_tv", 64'(thread_valid), 64'd0);
      chk("rst_done", 64'(warp_done), 64'd0);
      chk("rst_op1", 64'(thread_op1[5]), 64'd0);
      rst = 1'b1;
      tick();
      chk("post_rst_ready", 64'(in_ready), 64'd1);

      // Full warp, all cores ready
      core_ready = '1;
      offer('1, 6'h0A, 1'b1);
      expect_done(2);
      tick();
      in_valid = 1'b0;
      chk("full_tv", 64'(thread_valid), 64'hFFFF_FFFF);
      chk("full_busy", 64'(busy), 64'd1);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_opcode", 64'(thread_opcode[7]), 64'h0A);
      tick();
      chk("full_tv_clear", 64'(thread_valid), 64'd0);
      chk("full_ready_back", 64'(in_ready), 64'd1);
      tick();
      chk("full_done_once", 64'(warp_done), 64'd0);

      // Partial readiness across two cycles
      core_ready = 32'h3;
`ifdef WARP_ISSUE_PERF_EN
      stall0 = perf_stall_cycles;
`endif
      offer(32'hF, 6'h15, 1'b0);
      expect_done(3);
      tick();
      in_valid = 1'b0;
      chk("part_tv0", 64'(thread_valid), 64'hF);
      tick();
      chk("part_tv1", 64'(thread_valid), 64'hC);
      core_ready = 32'hC;
      tick();
      chk("part_tv2", 64'(thread_valid), 64'h0);
      chk("part_ready", 64'(in_ready), 64'd1);
`ifdef WARP_ISSUE_PERF_EN
      chk("part_stall", 64'(perf_stall_cycles - stall0), 64'd1);
`endif

      // Empty mask completes without issuing
      core_ready = '0;
      offer('0, 6'h21, 1'b1);
      expect_done(1);
      tick();
      in_valid = 1'b0;
      chk("empty_tv", 64'(thread_valid), 64'd0);
      chk("empty_busy", 64'(busy), 64'd0);
      chk("empty_done_now", 64'(warp_done), 64'd1);
      tick();

      // New offers while busy are ignored
      offer(32'hFF, 6'h2B, 1'b0);
      expect_done(4);
      op1_hold = in_op1[3];
      tick();
      offer(32'hFFFF_0000, 6'h3F, 1'b1);
      tick();
      tick();
      chk("hold_op1", 64'(thread_op1[3]), 64'(op1_hold));
      chk("hold_tv", 64'(thread_valid), 64'hFF);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      in_valid   = 1'b0;
      core_ready = '1;
      tick();
      chk("hold_after_tv", 64'(thread_valid), 64'd0);
      chk("hold_after_opc", 64'(thread_opcode[0]), 64'h2B);
      tick();

      // Reset while a warp is in flight drops it
      core_ready = '0;
      offer(32'h00FF_00FF, 6'h11, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("drop_tv", 64'(thread_valid), 64'h00FF_00FF);
      #2;
      rst = 1'b0;
      #1;
      chk("drop_tv_async", 64'(thread_valid), 64'd0);
      chk("drop_in_ready", 64'(in_ready), 64'd1);
      chk("drop_op1", 64'(thread_op1[0]), 64'd0);
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rel_in_ready", 64'(in_ready), 64'd1);
      chk("rel_busy", 64'(busy), 64'd0);
`ifdef WARP_ISSUE_PERF_EN
      chk("rel_perf_warps", 64'(perf_warps), 64'd0);
`endif
      tick();

      // Three back-to-back full warps
      core_ready = '1;
      for (int k = 0; k < 3; k++) begin
         offer('1, 6'(k + 1), k[0]);
         expect_done(2);
         tick();
         in_valid = 1'b0;
         chk("b2b_tv", 64'(thread_valid), 64'hFFFF_FFFF);
         tick();
         chk("b2b_ready", 64'(in_ready), 64'd1);
      end
      tick();
`ifdef WARP_ISSUE_PERF_EN
      chk("b2b_perf_warps", 64'(perf_warps), 64'd3);
      chk("b2b_perf_stall", 64'(perf_stall_cycles), 64'd0);
`endif

      repeat (3) tick();
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/warp_issue_stage.md
WARP_ISSUE_STAGE -- requirements
Module: warp_issue_stage

Interface
REQ-001 SHALL have parameter W, default 32, operand width in bits.
REQ-002 SHALL have parameter NUM_THREADS, default 32, threads (lanes) per warp.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  warp instruction offered by scheduler.
REQ-006 SHALL have port in_ready  output  1  stage can accept a warp.
REQ-007 SHALL have port in_mask  input  NUM_THREADS  active-thread mask.
REQ-008 SHALL have port in_opcode  input  6  warp opcode.
REQ-009 SHALL have port in_is_fp  input  1  floating-point instruction flag.
REQ-010 SHALL have ports in_op1, in_op2  input  NUM_THREADS x W  per-thread operands.
REQ-011 SHALL have port core_ready  input  NUM_THREADS  per-lane core ready, same vector seen by the NoC dispatcher.
REQ-012 SHALL have port thread_valid  output  NUM_THREADS  per-lane pending instruction, to dispatcher.
REQ-013 SHALL have ports thread_opcode (NUM_THREADS x 6), thread_is_fp (NUM_THREADS), thread_op1/thread_op2 (NUM_THREADS x W)  output  per-lane payload to dispatcher.
REQ-014 SHALL have port busy  output  1  high while a warp is in flight.
REQ-015 SHALL have port warp_done  output  1  one-cycle pulse when a warp fully dispatches.

Function
REQ-016 SHALL implement a two-state FSM: IDLE, ISSUE.
REQ-017 in_ready SHALL equal (state==IDLE); busy SHALL equal (state==ISSUE).
REQ-018 On in_valid&&in_ready at edge N, SHALL register opcode, is_fp (broadcast to all lanes), op1, op2; set pending<=in_mask; thread_valid=pending visible from cycle N+1.
REQ-019 Accepted warp with in_mask==0 SHALL stay IDLE and pulse warp_done in cycle N+1.
REQ-020 Accepted warp with nonzero mask SHALL enter ISSUE.
REQ-021 In ISSUE, each edge SHALL update pending<=pending & ~core_ready; a lane is dispatched in a cycle where its thread_valid and core_ready are both 1.
REQ-022 When pending & ~core_ready == 0 in ISSUE, SHALL return to IDLE and pulse warp_done in the following cycle; next warp acceptable in that same following cycle.
REQ-023 Payload outputs SHALL be stable while the lane's pending bit is set; lanes not pending hold the last captured value.
REQ-024 in_valid with in_ready low SHALL be ignored; inputs not sampled.
REQ-025 core_ready on non-pending lanes SHALL have no effect.
REQ-026 Minimum latency accept-to-warp_done with all lanes ready SHALL be 2 cycles.

Reset
REQ-027 rst low SHALL asynchronously force state=IDLE, pending=0, all payload registers 0, warp_done=0, counters 0.
REQ-028 Reset mid-ISSUE SHALL drop the warp with no warp_done pulse; in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-029 Macro WARP_ISSUE_PERF_EN defined SHALL add outputs perf_warps (32) and perf_stall_cycles (32).
REQ-030 perf_warps SHALL increment on each warp_done pulse; perf_stall_cycles SHALL increment each ISSUE cycle where (pending & ~core_ready)!=0; both wrap at 2^32.
REQ-031 Without WARP_ISSUE_PERF_EN the ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-032 Reset, then mask=0xFFFFFFFF, opcode=6'h0A, core_ready all 1 -> thread_valid all 1 for exactly 1 cycle, warp_done 2 cycles after accept, in_ready high again.
REQ-033 mask=0x0000000F, core_ready=0x3 then 0xC next cycle -> thread_valid 0xF, then 0xC, then 0; warp_done once; perf_stall_cycles=1.
REQ-034 mask=0 accepted -> no thread_valid, warp_done pulse next cycle, state stays IDLE.
REQ-035 in_valid held during ISSUE with different payload -> ignored; thread_op1 unchanged until warp_done.
REQ-036 rst asserted while pending=0x00FF00FF -> thread_valid=0 immediately, no warp_done, in_ready=1 after release.
REQ-037 Three back-to-back full warps, core_ready all 1 -> perf_warps=3, perf_stall_cycles=0.
